// File: rtl/oled_text_streamer_pkg.sv
// Shared font definitions for the OLED text path: pixel/glyph types, glyph geometry,
// streamer FSM states and the 8x8 glyph table (space, 0-9, A-Z).
package oled_text_streamer_pkg;

    typedef logic [15:0]     pixel_rgb565_t;
    typedef logic [7:0][7:0] glyph_rows_t;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } stream_state_t;

    // Each constant lists glyph row 0 in the most significant byte; bit 0 of a row is the leftmost pixel.
    function automatic glyph_rows_t font_glyph(input logic [7:0] ascii);
        case (ascii)
            8'h20:   font_glyph = 64'h0000000000000000;
            8'h30:   font_glyph = 64'h3E63737B6F673E00;
            8'h31:   font_glyph = 64'h0C0E0C0C0C0C3F00;
            8'h32:   font_glyph = 64'h1E33301C06333F00;
            8'h33:   font_glyph = 64'h1E33301C30331E00;
            8'h34:   font_glyph = 64'h383C36337F307800;
            8'h35:   font_glyph = 64'h3F031F3030331E00;
            8'h36:   font_glyph = 64'h1C06031F33331E00;
            8'h37:   font_glyph = 64'h3F3330180C0C0C00;
            8'h38:   font_glyph = 64'h1E33331E33331E00;
            8'h39:   font_glyph = 64'h1E33333E30180E00;
            8'h41:   font_glyph = 64'h0C1E33333F333300;
            8'h42:   font_glyph = 64'h3F66663E66663F00;
            8'h43:   font_glyph = 64'h3C66030303663C00;
            8'h44:   font_glyph = 64'h1F36666666361F00;
            8'h45:   font_glyph = 64'h7F46161E16467F00;
            8'h46:   font_glyph = 64'h7F46161E16060F00;
            8'h47:   font_glyph = 64'h3C66030373667C00;
            8'h48:   font_glyph = 64'h3333333F33333300;
            8'h49:   font_glyph = 64'h1E0C0C0C0C0C1E00;
            8'h4A:   font_glyph = 64'h7830303033331E00;
            8'h4B:   font_glyph = 64'h6766361E36666700;
            8'h4C:   font_glyph = 64'h0F06060646667F00;
            8'h4D:   font_glyph = 64'h63777F7F6B636300;
            8'h4E:   font_glyph = 64'h63676F7B73636300;
            8'h4F:   font_glyph = 64'h1C36636363361C00;
            8'h50:   font_glyph = 64'h3F66663E06060F00;
            8'h51:   font_glyph = 64'h1E3333333B1E3800;
            8'h52:   font_glyph = 64'h3F66663E36666700;
            8'h53:   font_glyph = 64'h1E33070E38331E00;
            8'h54:   font_glyph = 64'h3F2D0C0C0C0C1E00;
            8'h55:   font_glyph = 64'h3333333333333F00;
            8'h56:   font_glyph = 64'h33333333331E0C00;
            8'h57:   font_glyph = 64'h6363636B7F776300;
            8'h58:   font_glyph = 64'h6363361C1C366300;
            8'h59:   font_glyph = 64'h3333331E0C0C1E00;
            8'h5A:   font_glyph = 64'h7F6331184C667F00;
            default: font_glyph = 64'h0000000000000000;
        endcase
    endfunction

endpackage

// File: rtl/glyph_row_rom.sv
// Combinational glyph row lookup: one 8-pixel row byte for an ASCII code and row index.
// Codes outside the font table read back as a blank row.
module glyph_row_rom
    import oled_text_streamer_pkg::*;
(
    input  logic [7:0] ascii,
    input  logic [2:0] row,
    output logic [7:0] row_byte
);

    glyph_rows_t glyph;

    always_comb begin
        glyph    = font_glyph(ascii);
        row_byte = glyph[3'd7 - row];
    end

endmodule

// File: rtl/oled_text_streamer.sv
// Renders a short ASCII string as a raster-ordered RGB565 pixel stream (row-major across the
// whole string) with a valid/ready handshake toward the OLED panel driver.
module oled_text_streamer
    import oled_text_streamer_pkg::*;
#(
    parameter int            NUM_CHARS = 3,
    parameter pixel_rgb565_t FG_COLOR  = 16'hFFFF,
    parameter pixel_rgb565_t BG_COLOR  = 16'h0000
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_CHARS-1:0] text_ascii,
    input  logic                   abort,
    output logic [15:0]            pix_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] LAST_CHAR = 4'(NUM_CHARS - 1);
    localparam logic [2:0] LAST_COL  = 3'(GLYPH_W - 1);
    localparam logic [2:0] LAST_ROW  = 3'(GLYPH_H - 1);

    stream_state_t          state_reg, state_next;
    logic [8*NUM_CHARS-1:0] text_reg;
    logic [2:0]             col_reg, col_next;
    logic [3:0]             char_reg, char_next;
    logic [2:0]             row_reg, row_next;
    logic [7:0]             row_byte_reg, row_byte_next;
    logic [7:0]             char_codes [16];
    logic [3:0]             fetch_char;
    logic [2:0]             fetch_row;
    logic [7:0]             fetch_byte;
    logic                   last_beat;

    // Unpack the string so char 0 (the MSByte) is element 0; unused slots read as blank.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chars
            if (gi < NUM_CHARS) begin : g_used
                assign char_codes[gi] = text_reg[8*(NUM_CHARS-1-gi) +: 8];
            end else begin : g_unused
                assign char_codes[gi] = 8'h00;
            end
        end
    endgenerate

    glyph_row_rom u_rom (
        .ascii    (char_codes[fetch_char]),
        .row      (fetch_row),
        .row_byte (fetch_byte)
    );

    assign last_beat = (col_reg == LAST_COL) && (char_reg == LAST_CHAR) && (row_reg == LAST_ROW);

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        char_next     = char_reg;
        row_next      = row_reg;
        row_byte_next = row_byte_reg;
        // The lookup always targets the (char,row) that follows the current glyph row segment,
        // so the byte is ready the moment col 7 is handed off; LOAD uses (0,0).
        fetch_char    = '0;
        fetch_row     = '0;
        if (state_reg == ST_STREAM) begin
            if (char_reg == LAST_CHAR) begin
                fetch_row = row_reg + 3'd1;
            end else begin
                fetch_char = char_reg + 4'd1;
                fetch_row  = row_reg;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    col_next      = '0;
                    char_next     = '0;
                    row_next      = '0;
                    row_byte_next = fetch_byte;
                    state_next    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (pix_ready) begin
                    col_next = col_reg + 3'd1;
                    if (col_reg == LAST_COL) begin
                        row_byte_next = fetch_byte;
                        char_next     = fetch_char;
                        row_next      = fetch_row;
                    end
                    if (last_beat) state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            text_reg     <= '0;
            col_reg      <= '0;
            char_reg     <= '0;
            row_reg      <= '0;
            row_byte_reg <= '0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            char_reg     <= char_next;
            row_reg      <= row_next;
            row_byte_reg <= row_byte_next;
            if (state_reg == ST_IDLE && start) text_reg <= text_ascii;
        end
    end

    // Outputs decode registered state only, so they hold during stalls and clear with reset.
    assign pix_valid = (state_reg == ST_STREAM);
    assign pix_data  = (pix_valid && row_byte_reg[col_reg]) ? FG_COLOR : BG_COLOR;
    assign pix_last  = pix_valid && last_beat;
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_STREAM);
    assign done      = (state_reg == ST_DONE);

endmodule
